// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one line-wide L2 port between the L1 I-cache and D-cache.
// One transaction outstanding at a time; address/op/write data latched at grant; sticky watchdog.
module l2_arbiter #(
  parameter int unsigned S_LINE  = 256,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic              i_resp,
  output logic [S_LINE-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [S_LINE-1:0] d_wdata,
  output logic              d_resp,
  output logic [S_LINE-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [3:0]        l2_byte_enable,
  output logic [31:0]       l2_address,
  output logic [S_LINE-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [S_LINE-1:0] l2_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [31:0]         addr_q, addr_d;
  logic [S_LINE-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic                err_q, err_d;
  logic [3:0]          be_q;
  logic                ireq, dreq, serve;

  assign ireq  = i_read;
  assign dreq  = d_read | d_write;
  assign serve = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    unique case (state_q)
      IDLE: begin
        // On conflict I wins only if D took the previous grant.
        if (ireq && (!dreq || last_d_q)) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_address & LINE_MASK;
          write_d  = 1'b0;
        end else if (dreq) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_address & LINE_MASK;
          wdata_d  = d_wdata;
          write_d  = d_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d = wd_q;
    if (!serve || l2_resp) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end
    err_d = err_q | (serve && (wd_q == CNT_W'(TIMEOUT - 1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      be_q     <= '1;
    end
  end

  assign l2_read        = serve & ~write_q;
  assign l2_write       = serve & write_q;
  assign l2_address     = addr_q;
  assign l2_wdata       = wdata_q;
  assign l2_byte_enable = be_q;
  assign i_resp         = (state_q == SERVE_I) & l2_resp;
  assign d_resp         = (state_q == SERVE_D) & l2_resp;
  assign i_rdata        = i_resp ? l2_rdata : '0;
  assign d_rdata        = d_resp ? l2_rdata : '0;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level owner/latch model.
module tb_l2_arbiter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata;
  logic         i_resp, d_resp;
  logic [255:0] i_rdata, d_rdata;
  logic         l2_read, l2_write;
  logic [3:0]   l2_byte_enable;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic         l2_resp;
  logic [255:0] l2_rdata;
  logic         err_timeout;

  l2_arbiter #(.S_LINE(256), .TIMEOUT(TO), .CNT_W(11)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_byte_enable(l2_byte_enable),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: who owns the L2 port, and what was captured when it was granted.
  int           m_owner;   // 0 none, 1 I, 2 D
  int           m_last;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic         m_wr;
  int           m_cnt;     // serve cycles elapsed in current transaction
  logic         m_err;
  int           m_pick;

  function automatic int pick(logic ir, logic dr, int last);
    if (ir && dr) return (last == 1) ? 2 : 1;
    if (ir) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  assign m_pick = pick(i_read, d_read | d_write, m_last);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner <= 0; m_last <= 2; m_addr <= '0; m_wdata <= '0;
      m_wr <= 1'b0; m_cnt <= 0; m_err <= 1'b0;
    end else if (m_owner == 0) begin
      if (m_pick != 0) begin
        m_owner <= m_pick;
        m_last  <= m_pick;
        m_cnt   <= 0;
        if (m_pick == 1) begin
          m_addr <= i_address & 32'hFFFF_FFE0;
          m_wr   <= 1'b0;
        end else begin
          m_addr  <= d_address & 32'hFFFF_FFE0;
          m_wr    <= d_write;
          m_wdata <= d_wdata;
        end
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == TO) m_err <= 1'b1;
      if (l2_resp) m_owner <= 0;
    end
  end

  // L2 responder: raises l2_resp once the strobe has been seen for lat cycles.
  int lat = 1;
  int rcnt;
  logic seen, was;
  initial begin
    l2_resp = 1'b0; l2_rdata = '0; rcnt = 0;
    forever begin
      @(negedge clk);
      seen = rst && (l2_read || l2_write);
      was  = l2_resp;
      @(posedge clk); #1;
      l2_rdata = r256();
      if (!rst || was) begin
        l2_resp = 1'b0; rcnt = 0;
      end else if (seen) begin
        rcnt++;
        if (rcnt >= lat) l2_resp = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic compare_all();
    logic busy, er, dr;
    if (!rst) begin
      chk("rst_l2_read", l2_read, 0);   chk("rst_l2_write", l2_write, 0);
      chk("rst_i_resp", i_resp, 0);     chk("rst_d_resp", d_resp, 0);
      chk("rst_addr", l2_address, 0);   chk("rst_wdata", l2_wdata, 0);
      chk("rst_be", l2_byte_enable, 0); chk("rst_err", err_timeout, 0);
      chk("rst_i_rdata", i_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
    end else begin
      busy = (m_owner != 0);
      er = (m_owner == 1) && l2_resp;
      dr = (m_owner == 2) && l2_resp;
      chk("l2_read", l2_read, busy && !m_wr);
      chk("l2_write", l2_write, busy && m_wr);
      chk("i_resp", i_resp, er);
      chk("d_resp", d_resp, dr);
      chk("i_rdata", i_rdata, er ? l2_rdata : 256'd0);
      chk("d_rdata", d_rdata, dr ? l2_rdata : 256'd0);
      chk("err_timeout", err_timeout, m_err);
      if (busy) begin
        chk("l2_address", l2_address, m_addr);
        chk("l2_byte_enable", l2_byte_enable, 4'hF);
        if (m_wr) chk("l2_wdata", l2_wdata, m_wdata);
      end
    end
  endtask

  logic s_ir, s_dr, s_rd, s_wr, s_err;
  logic [31:0]  s_addr;
  logic [255:0] s_wdata, s_irdata, s_l2rdata;

  task automatic tick();
    @(negedge clk);
    compare_all();
    s_ir = i_resp; s_dr = d_resp; s_rd = l2_read; s_wr = l2_write; s_err = err_timeout;
    s_addr = l2_address; s_wdata = l2_wdata; s_irdata = i_rdata; s_l2rdata = l2_rdata;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0;
    tick(); tick();
    rst = 1'b1;
  endtask

  int rc, ec, nw, nd, bad, ni, ndq, op;
  int order[$];
  int exp_order[8] = '{1, 2, 1, 2, 1, 2, 1, 2};
  logic [255:0] a5;

  initial begin
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    a5 = {32{8'hA5}};
    #1;
    do_reset();

    // 1: I read, L2 latency 3
    lat = 3; i_read = 1; i_address = 32'h0000_1234; rc = 99; nw = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 1) begin
        chk("t1_l2_read_c1", s_rd, 1);
        chk("t1_addr", s_addr, 32'h0000_1220);
      end
      if (s_wr) nw++;
      if (s_ir) begin
        if (rc == 99) rc = c;
        chk("t1_rdata", s_irdata, s_l2rdata);
        i_read = 0;
      end
    end
    chk("t1_resp_cycle", rc, 4);
    chk("t1_no_write", nw, 0);

    // 2: D write, wdata changes after grant
    lat = 2; d_write = 1; d_address = 32'h80; d_wdata = a5; nw = 0; nd = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      d_wdata = r256();
      if (c == 1) chk("t2_addr", s_addr, 32'h80);
      if (s_wr) begin
        nw++;
        if (s_wdata !== a5) bad++;
      end
      if (s_dr) begin nd++; d_write = 0; end
    end
    chk("t2_wdata_held", bad, 0);
    chk("t2_write_cycles", nw, 3);
    chk("t2_dresp_count", nd, 1);

    // 3: simultaneous requests out of reset alternate I,D,...
    do_reset();
    lat = 1; i_read = 1; d_read = 1; i_address = 32'h100; d_address = 32'h200;
    ni = 1; ndq = 1; order.delete();
    for (int c = 0; c < 200 && order.size() < 8; c++) begin
      tick();
      if (s_ir) order.push_back(1);
      if (s_dr) order.push_back(2);
      if (s_ir) i_read = 0;
      else if (!i_read && ni < 4) begin i_read = 1; ni++; end
      if (s_dr) d_read = 0;
      else if (!d_read && ndq < 4) begin d_read = 1; ndq++; end
    end
    i_read = 0; d_read = 0;
    chk("t3_count", order.size(), 8);
    for (int k = 0; k < 8 && k < order.size(); k++) chk($sformatf("t3_order%0d", k), order[k], exp_order[k]);
    tick(); tick();

    // 6: D read dropped one cycle after grant
    lat = 3; d_read = 1; d_address = 32'h3C0; rc = 99; nw = 0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) d_read = 0;
      if (s_rd) nw++;
      if (s_dr) begin nd++; if (rc == 99) rc = c; end
      if (c == 5) chk("t6_idle_after", s_rd, 0);
    end
    chk("t6_read_cycles", nw, 4);
    chk("t6_resp_cycle", rc, 4);
    chk("t6_resp_count", nd, 1);

    // 4: watchdog with late response
    lat = 20; i_read = 1; i_address = 32'h7000; rc = 99; ec = 99;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_err && ec == 99) ec = c;
      if (s_ir) begin if (rc == 99) rc = c; i_read = 0; end
    end
    chk("t4_err_cycle", ec, 17);
    chk("t4_late_resp", rc, 21);
    chk("t4_err_sticky", s_err, 1);

    // 5: async reset mid SERVE_D
    lat = 20; d_read = 1; d_address = 32'h4000;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("t5_l2_read", l2_read, 0);   chk("t5_d_resp", d_resp, 0);
    chk("t5_addr", l2_address, 0);   chk("t5_be", l2_byte_enable, 0);
    chk("t5_err", err_timeout, 0);   chk("t5_wdata", l2_wdata, 0);
    d_read = 0;
    tick(); tick();
    rst = 1'b1;
    lat = 2; i_read = 1; i_address = 32'h2468; rc = 99; nd = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_dr) nd++;
      if (s_ir) begin if (rc == 99) rc = c; i_read = 0; end
    end
    chk("t5_new_grant", rc, 3);
    chk("t5_no_dresp", nd, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      lat = $urandom_range(1, 4);
      d_wdata = r256();
      if (i_read && s_ir) i_read = 0;
      else if (i_read && $urandom_range(0, 31) == 0) i_read = 0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1; i_address = $urandom; end
      if ((d_read || d_write) && s_dr) begin d_read = 0; d_write = 0; end
      else if ((d_read || d_write) && $urandom_range(0, 31) == 0) begin d_read = 0; d_write = 0; end
      else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 7);
        d_read = (op < 4) || (op == 7);
        d_write = (op >= 4);
        d_address = $urandom;
      end
    end
    i_read = 0; d_read = 0; d_write = 0;
    for (int n = 0; n < 8; n++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
